// File: rtl/risc16_seq_alu_if.sv
// -----------------------------------------------------------------------------
// risc16_seq_alu_if
// Handshake bundle between operand fetch (master), the sequential ALU (slave)
// and writeback.
//   in_valid/in_ready : operation request handshake, carries src1/src2/funct
//   out_valid/out_ready : result handshake, carries result/state/carry
// -----------------------------------------------------------------------------
interface risc16_seq_alu_if #(
  parameter int WORD_LENGTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WORD_LENGTH-1:0] src1;
  logic [WORD_LENGTH-1:0] src2;
  logic [2:0]             funct;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_LENGTH-1:0] result;
  logic                   state;
  logic                   carry;

  modport master (
    output in_valid, src1, src2, funct, out_ready,
    input  in_ready, out_valid, result, state, carry
  );

  modport slave (
    input  in_valid, src1, src2, funct, out_ready,
    output in_ready, out_valid, result, state, carry
  );
endinterface

// File: rtl/risc16_seq_alu.sv
// -----------------------------------------------------------------------------
// risc16_seq_alu
// Handshaked RiSC16 ALU with multi-cycle shift-add multiply and bit-serial
// variable shifts.
// Ports:
//   clk   : rising-edge system clock
//   rst_n : asynchronous active-low reset
//   bus   : risc16_seq_alu_if slave (request in, result/state/carry out)
// funct: 0 ADD, 1 SUB, 2 NAND, 3 PASS, 4 MUL, 5 SHL, 6 SHR, 7 SRA
// -----------------------------------------------------------------------------
module risc16_seq_alu #(
  parameter  int WORD_LENGTH = 16,
  localparam int SHAMT_W     = $clog2(WORD_LENGTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  risc16_seq_alu_if.slave   bus
);
  // Counter needs one extra bit so it can hold WORD_LENGTH for MUL.
  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [2:0] F_ADD  = 3'd0;
  localparam logic [2:0] F_SUB  = 3'd1;
  localparam logic [2:0] F_NAND = 3'd2;
  localparam logic [2:0] F_PASS = 3'd3;
  localparam logic [2:0] F_MUL  = 3'd4;
  localparam logic [2:0] F_SHL  = 3'd5;
  localparam logic [2:0] F_SHR  = 3'd6;
  localparam logic [2:0] F_SRA  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t                   fsm_q, fsm_d;
  logic [WORD_LENGTH-1:0] a_q, a_d;        // multiplicand / shift operand
  logic [WORD_LENGTH-1:0] b_q, b_d;        // multiplier (consumed LSB first)
  logic [WORD_LENGTH-1:0] acc_q, acc_d;    // product accumulator
  logic [WORD_LENGTH-1:0] result_q, result_d;
  logic [2:0]             funct_q, funct_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   zero_q, zero_d;
  logic                   carry_q, carry_d;

  logic [WORD_LENGTH:0]   sum_s;
  logic [WORD_LENGTH:0]   diff_s;
  logic [SHAMT_W-1:0]     shamt_s;
  logic [WORD_LENGTH-1:0] step_a_s;
  logic [WORD_LENGTH-1:0] acc_next_s;

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      funct_q  <= 3'd0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      funct_q  <= funct_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  // Next-state, single-cycle arithmetic and one iteration step per cycle.
  always_comb begin
    fsm_d    = fsm_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    funct_d  = funct_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;

    // Single-cycle ops are evaluated straight from the inputs at the accept
    // edge; the same values are captured, so this matches using the copies.
    sum_s   = {1'b0, bus.src1} + {1'b0, bus.src2};
    diff_s  = {1'b0, bus.src1} + {1'b0, ~bus.src2} + {{WORD_LENGTH{1'b0}}, 1'b1};
    shamt_s = bus.src2[SHAMT_W-1:0];

    // MUL shifts the multiplicand left alongside SHL.
    case (funct_q)
      F_MUL, F_SHL: step_a_s = {a_q[WORD_LENGTH-2:0], 1'b0};
      F_SHR:        step_a_s = {1'b0, a_q[WORD_LENGTH-1:1]};
      F_SRA:        step_a_s = {a_q[WORD_LENGTH-1], a_q[WORD_LENGTH-1:1]};
      default:      step_a_s = a_q;
    endcase
    acc_next_s = b_q[0] ? (acc_q + a_q) : acc_q;

    case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          funct_d = bus.funct;
          a_d     = bus.src1;
          b_d     = bus.src2;
          acc_d   = '0;
          case (bus.funct)
            F_ADD: begin
              result_d = sum_s[WORD_LENGTH-1:0];
              carry_d  = sum_s[WORD_LENGTH];
              fsm_d    = DONE;
            end
            F_SUB: begin
              result_d = diff_s[WORD_LENGTH-1:0];
              carry_d  = diff_s[WORD_LENGTH];
              fsm_d    = DONE;
            end
            F_NAND: begin
              result_d = ~(bus.src1 & bus.src2);
              carry_d  = 1'b0;
              fsm_d    = DONE;
            end
            F_PASS: begin
              result_d = bus.src2;
              carry_d  = 1'b0;
              fsm_d    = DONE;
            end
            F_MUL: begin
              cnt_d = CNT_W'(WORD_LENGTH);
              fsm_d = ITER;
            end
            default: begin
              // Shifts; a zero amount completes like a single-cycle op.
              if (shamt_s == '0) begin
                result_d = bus.src1;
                carry_d  = 1'b0;
                fsm_d    = DONE;
              end else begin
                cnt_d = {1'b0, shamt_s};
                fsm_d = ITER;
              end
            end
          endcase
        end else begin
          fsm_d = IDLE;
        end
      end
      ITER: begin
        a_d   = step_a_s;
        b_d   = b_q >> 1;
        acc_d = acc_next_s;
        cnt_d = cnt_q - CNT_W'(1);
        // Last iteration writes its own step result straight into result.
        if (cnt_q == CNT_W'(1)) begin
          result_d = (funct_q == F_MUL) ? acc_next_s : step_a_s;
          carry_d  = 1'b0;
          fsm_d    = DONE;
        end else begin
          fsm_d = ITER;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d = IDLE;
        end else begin
          fsm_d = DONE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

    // Zero flag is refreshed only on entry to DONE, together with result.
    if ((fsm_d == DONE) && (fsm_q != DONE)) begin
      zero_d = (result_d == '0);
    end else begin
      zero_d = zero_q;
    end
  end

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.result    = result_q;
  assign bus.state     = zero_q;
  assign bus.carry     = carry_q;

endmodule
